// File: rtl/oled_frame_sequencer_if.sv
// Byte-engine link between oled_frame_sequencer and i2c_controller.
// The sequencer is the master; the engine answers with i2c_ready.
interface oled_frame_sequencer_if;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_data;
  logic       i2c_dc;
  logic       i2c_rw;
  logic       i2c_enable;
  logic       i2c_ready;

  modport master (
    output i2c_addr, i2c_data, i2c_dc, i2c_rw, i2c_enable,
    input  i2c_ready
  );

  modport slave (
    input  i2c_addr, i2c_data, i2c_dc, i2c_rw, i2c_enable,
    output i2c_ready
  );
endinterface

// File: rtl/oled_frame_sequencer.sv
// SSD1306 128x32 sequencer: power-up wait, init list, then framed
// refreshes (6-byte window header + framebuffer bytes) via the I2C engine.
module oled_frame_sequencer #(
  parameter logic [6:0] I2C_ADDR  = 7'h3C,
  parameter int         PWR_DELAY = 16,
  parameter int         FB_BYTES  = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_frame,
  output logic [8:0] fb_addr,
  input  logic [7:0] fb_data,
  output logic       init_done,
  output logic       busy,
  output logic       frame_done,
  oled_frame_sequencer_if.master i2c
);

  localparam logic [15:0] PWR_LAST  = 16'(PWR_DELAY - 1);
  localparam logic [8:0]  DATA_LAST = 9'(FB_BYTES - 1);
  localparam logic [4:0]  INIT_LAST = 5'd24;
  localparam logic [4:0]  HDR_LAST  = 5'd5;

  typedef enum logic [2:0] {
    S_PWR, S_INIT, S_IDLE, S_HDR, S_DATA
  } state_t;

  typedef enum logic [1:0] {
    P_ISSUE, P_ACCEPT, P_DONE
  } phase_t;

  state_t      state, state_d;
  phase_t      phase, phase_d;
  logic [15:0] cnt, cnt_d;
  logic [4:0]  idx, idx_d;
  logic [8:0]  didx, didx_d;
  logic [8:0]  fb_addr_d;
  logic [7:0]  byte_q, byte_d;
  logic        dc_q, dc_d;
  logic        en_q, en_d;
  logic        init_done_d;
  logic        frame_done_d;
  logic        pend, pend_d;
  logic [7:0]  src;

  function automatic logic [7:0] init_rom(input logic [4:0] i);
    case (i)
      5'd0:    return 8'hAE;
      5'd1:    return 8'hD5;
      5'd2:    return 8'h80;
      5'd3:    return 8'hA8;
      5'd4:    return 8'h1F;
      5'd5:    return 8'hD3;
      5'd6:    return 8'h00;
      5'd7:    return 8'h40;
      5'd8:    return 8'h8D;
      5'd9:    return 8'h14;
      5'd10:   return 8'h20;
      5'd11:   return 8'h00;
      5'd12:   return 8'hA1;
      5'd13:   return 8'hC8;
      5'd14:   return 8'hDA;
      5'd15:   return 8'h02;
      5'd16:   return 8'h81;
      5'd17:   return 8'h8F;
      5'd18:   return 8'hD9;
      5'd19:   return 8'hF1;
      5'd20:   return 8'hDB;
      5'd21:   return 8'h40;
      5'd22:   return 8'hA4;
      5'd23:   return 8'hA6;
      5'd24:   return 8'hAF;
      default: return 8'h00;
    endcase
  endfunction

  // Column 0..127, page 0..3 address window.
  function automatic logic [7:0] hdr_rom(input logic [4:0] i);
    case (i)
      5'd0:    return 8'h21;
      5'd1:    return 8'h00;
      5'd2:    return 8'h7F;
      5'd3:    return 8'h22;
      5'd4:    return 8'h00;
      5'd5:    return 8'h03;
      default: return 8'h00;
    endcase
  endfunction

  assign busy           = (state != S_IDLE);
  assign i2c.i2c_addr   = I2C_ADDR;
  assign i2c.i2c_rw     = 1'b0;
  assign i2c.i2c_data   = byte_q;
  assign i2c.i2c_dc     = dc_q;
  assign i2c.i2c_enable = en_q;

  // Byte source for the list currently being sent.
  always_comb begin
    src = fb_data;
    if (state == S_INIT) src = init_rom(idx);
    else if (state == S_HDR) src = hdr_rom(idx);
  end

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_PWR;
      phase      <= P_ISSUE;
      cnt        <= '0;
      idx        <= '0;
      didx       <= '0;
      fb_addr    <= '0;
      byte_q     <= '0;
      dc_q       <= 1'b0;
      en_q       <= 1'b0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
      pend       <= 1'b0;
    end else begin
      state      <= state_d;
      phase      <= phase_d;
      cnt        <= cnt_d;
      idx        <= idx_d;
      didx       <= didx_d;
      fb_addr    <= fb_addr_d;
      byte_q     <= byte_d;
      dc_q       <= dc_d;
      en_q       <= en_d;
      init_done  <= init_done_d;
      frame_done <= frame_done_d;
      pend       <= pend_d;
    end
  end

  // Next state: power-up count, list walking, per-byte handshake.
  // fb_addr runs one byte ahead so registered RAM data is ready by ISSUE.
  always_comb begin
    state_d      = state;
    phase_d      = phase;
    cnt_d        = cnt;
    idx_d        = idx;
    didx_d       = didx;
    fb_addr_d    = fb_addr;
    byte_d       = byte_q;
    dc_d         = dc_q;
    en_d         = 1'b0;
    init_done_d  = init_done;
    frame_done_d = 1'b0;
    pend_d       = pend | start_frame;

    unique case (state)
      S_PWR: begin
        if (cnt == PWR_LAST) begin
          state_d = S_INIT;
          phase_d = P_ISSUE;
          idx_d   = '0;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_IDLE: begin
        if (start_frame || pend) begin
          state_d = S_HDR;
          phase_d = P_ISSUE;
          idx_d   = '0;
          pend_d  = 1'b0;
        end
      end
      default: begin
        unique case (phase)
          P_ISSUE: begin
            byte_d = src;
            dc_d   = (state == S_DATA);
            if (i2c.i2c_ready) begin
              en_d    = 1'b1;
              phase_d = P_ACCEPT;
              if (state == S_DATA && didx != DATA_LAST)
                fb_addr_d = didx + 9'd1;
            end
          end
          P_ACCEPT: begin
            if (!i2c.i2c_ready) phase_d = P_DONE;
          end
          default: begin
            if (i2c.i2c_ready) begin
              phase_d = P_ISSUE;
              if (state == S_INIT) begin
                if (idx == INIT_LAST) begin
                  init_done_d = 1'b1;
                  state_d     = S_IDLE;
                  idx_d       = '0;
                end else begin
                  idx_d = idx + 5'd1;
                end
              end else if (state == S_HDR) begin
                if (idx == HDR_LAST) begin
                  state_d = S_DATA;
                  didx_d  = '0;
                  idx_d   = '0;
                end else begin
                  idx_d = idx + 5'd1;
                end
              end else begin
                if (didx == DATA_LAST) begin
                  frame_done_d = 1'b1;
                  fb_addr_d    = '0;
                  didx_d       = '0;
                  state_d      = S_IDLE;
                end else begin
                  didx_d = didx + 9'd1;
                end
              end
            end
          end
        endcase
      end
    endcase
  end

endmodule
